sga_move_sequencer: RTL and testbench
=====================================

SGA_MOVE_SEQUENCER -- requirements
Module: sga_move_sequencer

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1: high while the game control unit is in a play state.
REQ-004 SHALL have port init, input, 1: single-cycle request to reload the initial snake.
REQ-005 SHALL have port tick, input, 1: single-cycle move pulse from the play timer.
REQ-006 SHALL have port buttons, input, 4: [3]=up, [2]=down, [1]=left, [0]=right.
REQ-007 SHALL have ports apple_x and apple_y, input, 3 each: current apple cell.
REQ-008 SHALL have port seg_idx, input, 4: read index, where 0 is the head.
REQ-009 SHALL have port seg_xy, output, 6: {x,y} of segment seg_idx; combinational.
REQ-010 SHALL have port seg_valid, output, 1: seg_idx < size; combinational.
REQ-011 SHALL have port size, output, 4: current snake length.
REQ-012 SHALL have port dir, output, 2: applied direction, encoded 0=up, 1=down, 2=left, 3=right.
REQ-013 SHALL have ports step_done, ate_apple, hit_border, hit_body, won, tick_overrun, output, 1 each: registered single-cycle pulses.
REQ-014 SHALL have port busy, output, 1: high in CALC, SCAN and UPDATE.

Function
REQ-015 Board SHALL be 6x6 with coordinates 0..5; y increases downward.
REQ-016 Body SHALL be stored in a 16x6 circular register buffer with a head pointer; segment i SHALL be located at (head_ptr - i) mod 16.
REQ-017 FSM states SHALL be IDLE, WAIT_TICK, CALC, SCAN, UPDATE, DONE and HALT.
REQ-018 Transitions SHALL be:
- IDLE->WAIT_TICK when enable=1.
- Any state->IDLE when enable=0, except HALT.
- HALT->IDLE only when enable=0.
REQ-019 Pending direction SHALL be sampled every cycle outside reset.
- Accept only one-hot buttons.
- Reject zero, multi-bit and the reverse of dir; on reject, keep the pending value.
REQ-020 Tick accepted in WAIT_TICK SHALL go to CALC; tick in any other state SHALL be ignored and SHALL pulse tick_overrun the next cycle.
REQ-021 CALC, 1 cycle, SHALL:
- Apply the pending direction to dir.
- Form the candidate head.
- If the candidate leaves 0..5, pulse hit_border and go to HALT without moving.
REQ-022 CALC SHALL set grow=1 when candidate == (apple_x, apple_y).
REQ-023 SCAN SHALL compare the candidate against one segment per cycle, index 0 upward.
- Scan N = size when grow=1, else N = size-1 (tail excluded, since it vacates).
REQ-024 On a SCAN match, the FSM SHALL pulse hit_body the next cycle, go to HALT and leave the body unmodified.
REQ-025 UPDATE SHALL write the candidate at head_ptr+1 mod 16 and advance head_ptr.
- When grow=1, size SHALL increment and ate_apple SHALL pulse.
REQ-026 If grow=1 and size==15, the block SHALL pulse won, leave size unchanged and go to HALT after UPDATE.
REQ-027 DONE SHALL pulse step_done and return to WAIT_TICK.
REQ-028 step_done SHALL be high exactly N+3 cycles after the accepted tick edge.
REQ-029 init SHALL reload the initial snake from any state; it SHALL win over tick in the same cycle; the FSM SHALL go to IDLE.
REQ-030 Pulse outputs SHALL never be high for two consecutive cycles.

Reset
REQ-031 On reset_n=0, the block SHALL set state IDLE, size=3, dir=3 (right), pending=right, head_ptr=2.
- Segments 0..2 = (2,2), (1,2), (0,2).
- All pulses and busy SHALL be 0.
REQ-032 Reset asserted mid-SCAN or mid-UPDATE SHALL abort the step with no buffer write committed.

Verification
REQ-033 Reset, enable=1, tick at cycle 0, apple at (5,5) -> step_done at cycle 5; segments (3,2), (2,2), (1,2); size=3.
REQ-034 Apple at (3,2), tick -> ate_apple, size=4, step_done at cycle 6; segment 3 = (0,2).
REQ-035 buttons=0010 (left) while dir=right -> dir stays 3; buttons=1000 (up) then tick -> head (2,1).
REQ-036 Four right ticks from reset -> 4th tick pulses hit_border; FSM in HALT; head stays (5,2).
REQ-037 Length-5 snake steered into its own body -> hit_body pulse; no further movement until enable toggles.
REQ-038 Size 15, candidate == apple -> won pulse; size stays 15; HALT; tick during busy -> tick_overrun pulse.

Source files
------------

// File: rtl/sga_move_sequencer.sv
// Snake move sequencer for a 6x6 board: steers, scans for self-collision,
// and commits one head step per accepted tick into a 16-entry ring buffer.
module sga_move_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       init,
    input  logic       tick,
    input  logic [3:0] buttons,
    input  logic [2:0] apple_x,
    input  logic [2:0] apple_y,
    input  logic [3:0] seg_idx,
    output logic [5:0] seg_xy,
    output logic       seg_valid,
    output logic [3:0] size,
    output logic [1:0] dir,
    output logic       step_done,
    output logic       ate_apple,
    output logic       hit_border,
    output logic       hit_body,
    output logic       won,
    output logic       tick_overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        CALC,
        SCAN,
        UPDATE,
        DONE,
        HALT
    } state_t;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    state_t     state;
    logic [5:0] body [16];
    logic [3:0] head_ptr;
    logic [3:0] scan_idx;
    logic [3:0] scan_last;
    logic [1:0] pending;
    logic [2:0] cand_x;
    logic [2:0] cand_y;
    logic       grow;

    logic       btn_onehot;
    logic [1:0] btn_dir;
    logic [5:0] head_xy;
    logic [5:0] scan_xy;
    logic [2:0] nx;
    logic [2:0] ny;
    logic       out_of_board;
    logic       hit_apple;

    function automatic logic [5:0] init_seg(input logic [3:0] i);
        init_seg = (i < 4'd3) ? {i[2:0], 3'd2} : 6'd0;
    endfunction

    always_comb begin
        btn_onehot = 1'b1;
        btn_dir    = RIGHT;
        unique case (buttons)
            4'b1000: btn_dir = UP;
            4'b0100: btn_dir = DOWN;
            4'b0010: btn_dir = LEFT;
            4'b0001: btn_dir = RIGHT;
            default: btn_onehot = 1'b0;
        endcase
    end

    assign head_xy = body[head_ptr];
    assign scan_xy = body[head_ptr - scan_idx];

    // Off-board moves wrap to 6 or 7 in 3 bits, so one compare covers both edges.
    always_comb begin
        nx = head_xy[5:3];
        ny = head_xy[2:0];
        unique case (pending)
            UP:      ny = head_xy[2:0] - 3'd1;
            DOWN:    ny = head_xy[2:0] + 3'd1;
            LEFT:    nx = head_xy[5:3] - 3'd1;
            default: nx = head_xy[5:3] + 3'd1;
        endcase
    end

    assign out_of_board = (nx > 3'd5) || (ny > 3'd5);
    assign hit_apple    = (nx == apple_x) && (ny == apple_y);

    assign seg_xy    = body[head_ptr - seg_idx];
    assign seg_valid = seg_idx < size;
    assign busy      = (state == CALC) || (state == SCAN) || (state == UPDATE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            size         <= 4'd3;
            dir          <= RIGHT;
            pending      <= RIGHT;
            head_ptr     <= 4'd2;
            scan_idx     <= 4'd0;
            scan_last    <= 4'd0;
            cand_x       <= 3'd0;
            cand_y       <= 3'd0;
            grow         <= 1'b0;
            step_done    <= 1'b0;
            ate_apple    <= 1'b0;
            hit_border   <= 1'b0;
            hit_body     <= 1'b0;
            won          <= 1'b0;
            tick_overrun <= 1'b0;
            for (int i = 0; i < 16; i++) body[i] <= init_seg(i[3:0]);
        end else begin
            step_done    <= 1'b0;
            ate_apple    <= 1'b0;
            hit_border   <= 1'b0;
            hit_body     <= 1'b0;
            won          <= 1'b0;
            tick_overrun <= tick && (state != WAIT_TICK) && !tick_overrun;

            if (btn_onehot && (btn_dir != (dir ^ 2'd1)))
                pending <= btn_dir;

            if (init) begin
                state    <= IDLE;
                size     <= 4'd3;
                dir      <= RIGHT;
                pending  <= RIGHT;
                head_ptr <= 4'd2;
                scan_idx <= 4'd0;
                grow     <= 1'b0;
                for (int i = 0; i < 16; i++) body[i] <= init_seg(i[3:0]);
            end else if (!enable) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: state <= WAIT_TICK;
                    WAIT_TICK: begin
                        if (tick) state <= CALC;
                    end
                    CALC: begin
                        dir      <= pending;
                        cand_x   <= nx;
                        cand_y   <= ny;
                        scan_idx <= 4'd0;
                        if (out_of_board) begin
                            hit_border <= 1'b1;
                            state      <= HALT;
                        end else begin
                            grow      <= hit_apple;
                            // The tail is only a hazard if it stays put.
                            scan_last <= hit_apple ? size - 4'd1 : size - 4'd2;
                            state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (scan_xy == {cand_x, cand_y}) begin
                            hit_body <= 1'b1;
                            state    <= HALT;
                        end else if (scan_idx == scan_last) begin
                            state <= UPDATE;
                        end else begin
                            scan_idx <= scan_idx + 4'd1;
                        end
                    end
                    UPDATE: begin
                        body[head_ptr + 4'd1] <= {cand_x, cand_y};
                        head_ptr              <= head_ptr + 4'd1;
                        if (grow) ate_apple <= 1'b1;
                        if (grow && size == 4'd15) begin
                            won   <= 1'b1;
                            state <= HALT;
                        end else begin
                            if (grow) size <= size + 4'd1;
                            step_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE: state <= WAIT_TICK;
                    HALT: state <= HALT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sga_move_sequencer.sv
// Randomised scoreboard bench for sga_move_sequencer against a
// queue-based snake model.
module tb_sga_move_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       init = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] buttons = 4'd0;
    logic [2:0] apple_x = 3'd5;
    logic [2:0] apple_y = 3'd5;
    logic [3:0] seg_idx = 4'd0;
    logic [5:0] seg_xy;
    logic       seg_valid;
    logic [3:0] size;
    logic [1:0] dir;
    logic       step_done, ate_apple, hit_border, hit_body, won;
    logic       tick_overrun, busy;

    sga_move_sequencer dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .init(init),
        .tick(tick), .buttons(buttons), .apple_x(apple_x), .apple_y(apple_y),
        .seg_idx(seg_idx), .seg_xy(seg_xy), .seg_valid(seg_valid),
        .size(size), .dir(dir), .step_done(step_done), .ate_apple(ate_apple),
        .hit_border(hit_border), .hit_body(hit_body), .won(won),
        .tick_overrun(tick_overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // kind: 0 step_done, 1 hit_border, 2 hit_body, 3 won
    typedef struct {
        int kind;
        int cyc;
        int ate;
    } ev_t;

    ev_t evq[$];
    int  ovq[$];

    int  sx[$];
    int  sy[$];
    int  mdir, mpend;
    bit  halted;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sx.delete();
        sy.delete();
        sx.push_back(2); sy.push_back(2);
        sx.push_back(1); sy.push_back(2);
        sx.push_back(0); sy.push_back(2);
        mdir   = 3;
        mpend  = 3;
        halted = 0;
    endtask

    logic [3:0] mon_code;
    ev_t        mon_ev;

    always @(negedge clock) begin
        if (reset_n) begin
            mon_code = {won, hit_body, hit_border, step_done};
            if (mon_code != 4'd0) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", int'(mon_code), 0);
                end else begin
                    mon_ev = evq.pop_front();
                    check("event_kind", int'(mon_code), 1 << mon_ev.kind);
                    check("event_cycle", cyc, mon_ev.cyc);
                    check("event_ate", int'(ate_apple), mon_ev.ate);
                end
            end else if (ate_apple) begin
                check("stray_ate_apple", 1, 0);
            end
            if (tick_overrun) begin
                if (ovq.size() == 0) check("unexpected_overrun", 1, 0);
                else check("overrun_cycle", cyc, ovq.pop_front());
            end
        end
    end

    task automatic step_wait();
        int w = 0;
        while ((evq.size() != 0 || ovq.size() != 0) && w < 60) begin
            @(negedge clock);
            #1;
            w++;
        end
        if (w >= 60) begin
            check("step_timeout", evq.size() + ovq.size(), 0);
            evq.delete();
            ovq.delete();
        end
    endtask

    task automatic check_snake();
        int len;
        len = sx.size();
        check("size", int'(size), len);
        check("dir", int'(dir), mdir);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            seg_idx = 4'(i);
            #2;
            check($sformatf("seg%0d_valid", i), int'(seg_valid), int'(i < len));
            if (i < len)
                check($sformatf("seg%0d_xy", i), int'(seg_xy), sx[i] * 8 + sy[i]);
        end
    endtask

    task automatic press_raw(logic [3:0] b);
        int d;
        @(negedge clock);
        buttons = b;
        if ($countones(b) == 1) begin
            d = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
            if (d != (mdir ^ 1)) mpend = d;
        end
        @(negedge clock);
        buttons = 4'd0;
    endtask

    task automatic press(int d);
        logic [3:0] b;
        b = 4'b1000;
        press_raw(b >> d);
    endtask

    task automatic set_apple(int x, int y);
        apple_x = 3'(x);
        apple_y = 3'(y);
    endtask

    task automatic apple_front();
        int fx, fy;
        fx = sx[0] + int'(mpend == 3) - int'(mpend == 2);
        fy = sy[0] + int'(mpend == 1) - int'(mpend == 0);
        if (fx < 0 || fx > 5 || fy < 0 || fy > 5)
            set_apple($urandom_range(0, 5), $urandom_range(0, 5));
        else
            set_apple(fx, fy);
    endtask

    task automatic do_tick(bit extra);
        int  t0, cx, cy, n, hit, len;
        bit  grow;
        @(negedge clock);
        tick = 1'b1;
        t0   = cyc;
        mdir = mpend;
        cx   = sx[0] + int'(mdir == 3) - int'(mdir == 2);
        cy   = sy[0] + int'(mdir == 1) - int'(mdir == 0);
        len  = sx.size();
        if (cx < 0 || cx > 5 || cy < 0 || cy > 5) begin
            evq.push_back('{1, t0 + 2, 0});
            halted = 1;
        end else begin
            grow = (cx == int'(apple_x)) && (cy == int'(apple_y));
            n    = grow ? len : len - 1;
            hit  = -1;
            for (int k = 0; k < n; k++)
                if (hit < 0 && sx[k] == cx && sy[k] == cy) hit = k;
            if (hit >= 0) begin
                evq.push_back('{2, t0 + 3 + hit, 0});
                halted = 1;
            end else begin
                sx.push_front(cx);
                sy.push_front(cy);
                if (!grow) begin
                    void'(sx.pop_back());
                    void'(sy.pop_back());
                end
                if (grow && sx.size() > 15) begin
                    void'(sx.pop_back());
                    void'(sy.pop_back());
                    evq.push_back('{3, t0 + n + 3, 1});
                    halted = 1;
                end else begin
                    evq.push_back('{0, t0 + n + 3, int'(grow)});
                end
            end
        end
        @(negedge clock);
        check("busy_in_calc", int'(busy), 1);
        tick = extra;
        if (extra) begin
            ovq.push_back(cyc + 1);
            @(negedge clock);
            tick = 1'b0;
        end
        step_wait();
    endtask

    task automatic do_init();
        @(negedge clock);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        model_reset();
    endtask

    task automatic recover(bit use_init, bit poke);
        if (poke) begin
            @(negedge clock);
            tick = 1'b1;
            ovq.push_back(cyc + 1);
            @(negedge clock);
            tick = 1'b0;
            step_wait();
            check_snake();
        end
        if (use_init) begin
            do_init();
        end else begin
            @(negedge clock);
            enable = 1'b0;
            @(negedge clock);
            enable = 1'b1;
            halted = 0;
        end
    endtask

    task automatic move(int d, bit front, bit extra);
        if (d >= 0) press(d);
        if (front) apple_front();
        else set_apple(5, 5);
        do_tick(extra);
        check_snake();
    endtask

    int serp[13] = '{3, 3, 3, 0, 2, 2, 2, 2, 2, 0, 3, 3, 3};

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'({step_done, ate_apple, hit_border,
                                    hit_body, won, tick_overrun}), 0);
        check_snake();
        reset_n = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);

        // plain step, no apple
        move(-1, 0, 0);
        // eat apple from the initial snake
        do_init();
        set_apple(3, 2);
        do_tick(0);
        check_snake();
        // reverse rejected, then turn up
        do_init();
        press(2);
        move(-1, 0, 0);
        do_init();
        press(2);
        move(0, 0, 0);
        // run into the right border
        do_init();
        for (int i = 0; i < 4; i++) move(-1, 0, 0);
        recover(0, 1);
        // grow to 15 along a serpentine, then win
        do_init();
        for (int i = 0; i < 13; i++) move(serp[i], 1, i == 4);
        recover(1, 1);
        // length-5 snake bites itself
        move(3, 1, 0);
        move(3, 1, 0);
        move(0, 0, 0);
        move(2, 0, 0);
        move(1, 0, 0);
        recover(0, 1);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 11) == 0) do_init();
            case ($urandom_range(0, 3))
                0, 1: press($urandom_range(0, 3));
                2:    press_raw(4'($urandom_range(0, 15)));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) apple_front();
            else set_apple($urandom_range(0, 5), $urandom_range(0, 5));
            do_tick($urandom_range(0, 4) == 0);
            check_snake();
            if (halted) recover($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // reset in the middle of a scan discards the step
        if (halted) recover(1, 0);
        do_init();
        set_apple(3, 2);
        do_tick(0);
        set_apple(5, 5);
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        #2;
        check("abort_busy", int'(busy), 0);
        check("abort_step_done", int'(step_done), 0);
        check_snake();
        reset_n = 1'b1;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
